// File: rtl/main_memory.sv
// Backing main memory for the cache/MESI subsystem: one word per address holding
// a data payload plus its MESI tag. Single port, synchronous write, registered read.
package definesPkg;
    localparam int SB_DATA_W = 64;
    localparam int PAGE_W    = 2;

    typedef enum logic [1:0] {
        INV       = 2'd0,
        SHARED    = 2'd1,
        EXCLUSIVE = 2'd2,
        MODIFIED  = 2'd3
    } Tmesi_state;

    typedef struct packed {
        logic [PAGE_W-1:0] Page_reference;
        logic [7:0]        Address_code;
    } Taddress;

    typedef struct packed {
        logic [SB_DATA_W-1:0] Data;
    } Tdata_sb;
endpackage

module main_memory
    import definesPkg::*;
#(
    parameter int PAGES  = 2,
    parameter int WORDS  = 256,
    parameter int DATA_W = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  Taddress    addr,
    input  Tdata_sb    wdata,
    input  logic       we,
    output Tdata_sb    rdata,
    input  Tmesi_state mesi_state_in,
    output Tmesi_state mesi_state_out
);
    localparam int DEPTH = PAGES * WORDS;
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        Tdata_sb    data;
        Tmesi_state mesi;
    } Tentry;

    if (WORDS != 256 || DATA_W != SB_DATA_W) begin : g_bad_cfg
        $error("main_memory: WORDS/DATA_W must match the definesPkg address and data types");
    end

    // Contents are set at power-up only; reset never touches the array.
    Tentry r_mem [DEPTH] = '{default: '{data: '0, mesi: INV}};

    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;

    // The range check also stops out-of-range pages from aliasing after truncation.
    assign w_in_range = (32'(addr.Page_reference) < PAGES);
    assign w_idx      = IDX_W'(32'(addr.Page_reference) * WORDS + 32'(addr.Address_code));

    always_ff @(posedge clk) begin
        if (!reset && we && w_in_range) begin
            r_mem[w_idx] <= '{data: wdata, mesi: mesi_state_in};
        end
    end

    // Read-first: the output register samples the old entry on a same-address write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata          <= '0;
            mesi_state_out <= INV;
        end else if (w_in_range) begin
            rdata          <= r_mem[w_idx].data;
            mesi_state_out <= r_mem[w_idx].mesi;
        end else begin
            rdata          <= '0;
            mesi_state_out <= INV;
        end
    end
endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: the driver queues expected read results and an
// independent monitor compares them one cycle after each checked access.
module tb_main_memory;
    import definesPkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    Taddress    addr = '0;
    Tdata_sb    wdata = '0;
    logic       we = 1'b0;
    Tdata_sb    rdata;
    Tmesi_state mesi_in = INV;
    Tmesi_state mesi_out;

    main_memory #(.PAGES(2), .WORDS(256), .DATA_W(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .addr           (addr),
        .wdata          (wdata),
        .we             (we),
        .rdata          (rdata),
        .mesi_state_in  (mesi_in),
        .mesi_state_out (mesi_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        Tmesi_state  t;
        string       nm;
    } exp_t;

    exp_t        q[$];
    logic        exp_vld = 1'b0;
    logic        chk_d   = 1'b0;
    int          n_vec   = 0;
    int          n_err   = 0;
    logic [63:0] sb_d [512];
    Tmesi_state  sb_t [512];

    always @(posedge clk) chk_d <= exp_vld;

    always @(negedge clk) begin
        if (chk_d) begin
            exp_t e;
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: output present with no expected entry");
            end else begin
                e = q.pop_front();
                if (rdata.Data !== e.d || mesi_out !== e.t) begin
                    n_err++;
                    $display("FAIL %s: got data=%h tag=%s, want data=%h tag=%s",
                             e.nm, rdata.Data, mesi_out.name(), e.d, e.t.name());
                end
            end
        end
    end

    task automatic access(input logic rst, input logic [1:0] pg, input logic [7:0] ac,
                          input logic w, input logic [63:0] d, input Tmesi_state t,
                          input logic chk, input logic [63:0] ed, input Tmesi_state et,
                          input string nm);
        exp_t e;
        @(negedge clk);
        reset          = rst;
        addr           = '{Page_reference: pg, Address_code: ac};
        we             = w;
        wdata.Data     = d;
        mesi_in        = t;
        exp_vld        = chk;
        if (chk) begin
            e.d = ed; e.t = et; e.nm = nm;
            q.push_back(e);
        end
        if (!rst && w && pg < 2) begin
            sb_d[int'(pg) * 256 + int'(ac)] = d;
            sb_t[int'(pg) * 256 + int'(ac)] = t;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        for (int i = 0; i < 512; i++) begin
            sb_d[i] = '0;
            sb_t[i] = INV;
        end

        // 1: reset state
        $display("-I-: Reset is Asserted");
        access(1, 0, 8'h00, 0, 0, INV, 1, 64'h0, INV, "reset_out");

        // 2: power-up contents
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 255; a++)
                access(0, 2'(p), 8'(a), 0, 0, INV, 1, 64'h0, INV, "powerup_sweep");

        // 3: basic write / read, no page aliasing
        access(0, 1, 8'h05, 1, 64'hDEADBEEF_CAFEF00D, SHARED, 1, 64'h0, INV, "wr_p1_old");
        access(0, 1, 8'h05, 0, 0, INV, 1, 64'hDEADBEEF_CAFEF00D, SHARED, "rd_p1_05");
        access(0, 0, 8'h05, 0, 0, INV, 1, 64'h0, INV, "rd_p0_05");

        // 4: read-during-write is read-first
        access(0, 0, 8'hFF, 1, 64'h1, MODIFIED, 0, 0, INV, "");
        access(0, 0, 8'hFF, 1, 64'h2, EXCLUSIVE, 1, 64'h1, MODIFIED, "rdw_old");
        access(0, 0, 8'hFF, 0, 0, INV, 1, 64'h2, EXCLUSIVE, "rdw_new");

        // out-of-range page: write dropped, read 0/INV, page 0 untouched
        access(0, 2, 8'h10, 1, 64'h1234_5678, MODIFIED, 0, 0, INV, "");
        access(0, 2, 8'h10, 0, 0, INV, 1, 64'h0, INV, "oor_rd");
        access(0, 0, 8'h10, 0, 0, INV, 1, 64'h0, INV, "oor_alias_p0");
        access(0, 3, 8'h05, 0, 0, INV, 1, 64'h0, INV, "oor_p3");

        // 5: random write sweep then read-back against the scoreboard
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 255; a++) begin
                r = {$urandom, $urandom};
                access(0, 2'(p), 8'(a), 1, r, INV, 0, 0, INV, "");
            end
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 256; a++)
                access(0, 2'(p), 8'(a), 0, 0, INV, 1, sb_d[p * 256 + a], sb_t[p * 256 + a],
                       "rand_readback");

        // 6: array survives reset; writes during reset are ignored
        access(0, 0, 8'h00, 1, 64'hA5A5_0000_1111_5A5A, EXCLUSIVE, 0, 0, INV, "");
        access(1, 0, 8'h00, 1, 64'hFFFF_FFFF_FFFF_FFFF, MODIFIED, 1, 64'h0, INV, "rst_out");
        access(0, 0, 8'h00, 0, 0, INV, 1, 64'hA5A5_0000_1111_5A5A, EXCLUSIVE, "post_rst");

        access(0, 0, 8'h00, 0, 0, INV, 0, 0, INV, "");
        access(0, 0, 8'h00, 0, 0, INV, 0, 0, INV, "");
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
